// File: rtl/led_pattern_visual.sv
// LED pattern engine with built-in tick prescaler: up, down, bounce and gray display modes, plus pause/single-step.
// Optional macro LED_INPUT_SYNC_EN adds two-flop synchronisers on pause, step and mode.
module led_pattern_visual #(
  parameter int M = 5000000,
  parameter int N = 23,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic         pause,
  input  logic         step,
  output logic         tick,
  output logic [W-1:0] LEDG
);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_GRAY   = 2'b11;

  localparam logic [N-1:0] PRE_LAST = N'(M - 1);

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ {1'b0, b[W-1:1]};
  endfunction

  logic [N-1:0] pre;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  dir_t         dir;
  dir_t         dir_next;
  logic [1:0]   mode_q;
  logic         step_q;
  logic         pause_in;
  logic         step_in;
  logic [1:0]   mode_in;
  logic         step_rise;
  logic         reload;
  logic         adv;

`ifdef LED_INPUT_SYNC_EN
  logic [1:0] pause_sync;
  logic [1:0] step_sync;
  logic [1:0] mode_meta;
  logic [1:0] mode_sync;

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_sync <= 2'b00;
      step_sync  <= 2'b00;
      mode_meta  <= 2'b00;
      mode_sync  <= 2'b00;
    end else begin
      pause_sync <= {pause_sync[0], pause};
      step_sync  <= {step_sync[0], step};
      mode_meta  <= mode;
      mode_sync  <= mode_meta;
    end
  end

  assign pause_in = pause_sync[1];
  assign step_in  = step_sync[1];
  assign mode_in  = mode_sync;
`else
  assign pause_in = pause;
  assign step_in  = step;
  assign mode_in  = mode;
`endif

  // Prescaler wraps at M-1; tick marks the cycle after the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      if (pre == PRE_LAST) begin
        pre <= '0;
      end else begin
        pre <= pre + N'(1);
      end
      tick <= (pre == PRE_LAST);
    end
  end

  assign step_rise = step_in & ~step_q;
  assign reload    = (mode_in != mode_q);
  assign adv       = (~pause_in & tick) | (pause_in & step_rise);

  // Pattern state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      dir    <= DIR_LEFT;
      mode_q <= MODE_UP;
      step_q <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      dir    <= dir_next;
      mode_q <= mode_in;
      step_q <= step_in;
    end
  end

  // A mode change reseeds the pattern and swallows any coincident advance.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (reload) begin
      case (mode_in)
        MODE_UP: begin
          cnt_next = '0;
          dir_next = dir;
        end
        MODE_DOWN: begin
          cnt_next = '1;
          dir_next = dir;
        end
        MODE_BOUNCE: begin
          cnt_next = W'(1);
          dir_next = DIR_LEFT;
        end
        MODE_GRAY: begin
          cnt_next = '0;
          dir_next = dir;
        end
        default: begin
          cnt_next = '0;
          dir_next = DIR_LEFT;
        end
      endcase
    end else if (adv) begin
      case (mode_q)
        MODE_UP: begin
          cnt_next = cnt + W'(1);
          dir_next = dir;
        end
        MODE_DOWN: begin
          cnt_next = cnt - W'(1);
          dir_next = dir;
        end
        MODE_BOUNCE: begin
          // An empty one-hot can only come from corruption; restart at bit 0.
          if (cnt == '0) begin
            cnt_next = W'(1);
            dir_next = DIR_LEFT;
          end else if (dir == DIR_LEFT) begin
            cnt_next = {cnt[W-2:0], 1'b0};
            if (cnt[W-2]) begin
              dir_next = DIR_RIGHT;
            end else begin
              dir_next = DIR_LEFT;
            end
          end else begin
            cnt_next = {1'b0, cnt[W-1:1]};
            if (cnt[1]) begin
              dir_next = DIR_LEFT;
            end else begin
              dir_next = DIR_RIGHT;
            end
          end
        end
        MODE_GRAY: begin
          cnt_next = cnt + W'(1);
          dir_next = dir;
        end
        default: begin
          cnt_next = cnt;
          dir_next = dir;
        end
      endcase
    end else begin
      cnt_next = cnt;
      dir_next = dir;
    end
  end

  // Display mapping straight from registers.
  always_comb begin
    if (mode_q == MODE_GRAY) begin
      LEDG = bin2gray(cnt);
    end else begin
      LEDG = cnt;
    end
  end

endmodule
